// File: rtl/ctrl.sv
// rtl/ctrl.sv - NTT/INTT/PWM/SCALE pass sequencer with twiddle address generation
module ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [2:0]  set_state,
    input  logic [3:0]  p_max,
    output logic        op,
    output logic [3:0]  p,
    output logic [8:0]  k,
    output logic [8:0]  i,
    output logic [10:0] gamma0,
    output logic [10:0] gamma1,
    output logic [2:0]  cur_state,
    output logic        ren,
    output logic        wen,
    output logic        special_add
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_NTT   = 3'b001,
        S_PWM   = 3'b010,
        S_INTT  = 3'b011,
        S_SCALE = 3'b100
    } state_t;

    state_t      state_q, state_n;
    logic [3:0]  pm_q, pm_n;
    logic [1:0]  drain_q, drain_n;
    logic        start_q;
    logic [1:0]  ren_pipe;

    logic        ren_n, op_n, sa_n;
    logic [8:0]  i_n, k_n, m_last;
    logic [3:0]  p_n, shamt;
    logic [10:0] g0_n, g1_n;
    logic [9:0]  twice, tw0, tw1;
    logic        launch, last_pass, legal;

    assign cur_state = state_q;

    // Next-state and next-output computation; every output is registered below
    always_comb begin
        state_n = state_q;
        ren_n   = ren;
        i_n     = i;
        p_n     = p;
        pm_n    = pm_q;
        drain_n = drain_q;

        legal  = (set_state >= 3'd1) && (set_state <= 3'd4);
        launch = start && !start_q && (state_q == S_IDLE) && legal;

        // M-1 for the latched p_max; p_max = 0 is illegal and collapses to a single-cycle pass
        if (pm_q == 4'd0)
            m_last = 9'd0;
        else
            m_last = (9'd1 << (pm_q - 4'd1)) - 9'd1;

        case (state_q)
            S_NTT:   last_pass = (p == pm_q);
            S_INTT:  last_pass = (p == 4'd0);
            default: last_pass = 1'b1;
        endcase

        if (state_q == S_IDLE) begin
            ren_n   = 1'b0;
            i_n     = 9'd0;
            p_n     = 4'd0;
            drain_n = 2'd0;
            if (launch) begin
                case (set_state)
                    3'b001:  state_n = S_NTT;
                    3'b010:  state_n = S_PWM;
                    3'b011:  state_n = S_INTT;
                    default: state_n = S_SCALE;
                endcase
                pm_n  = p_max;
                ren_n = 1'b1;
                p_n   = (set_state == 3'b011) ? p_max : 4'd0;
            end
        end else if (ren) begin
            if (i == m_last) begin
                ren_n   = 1'b0;
                i_n     = 9'd0;
                drain_n = 2'd0;
            end else begin
                i_n = i + 9'd1;
            end
        end else if (drain_q == 2'd2) begin
            // Third drain cycle: the last write of the pass lands now
            if (last_pass) begin
                state_n = S_IDLE;
                p_n     = 4'd0;
                i_n     = 9'd0;
            end else begin
                ren_n = 1'b1;
                i_n   = 9'd0;
                p_n   = (state_q == S_NTT) ? p + 4'd1 : p - 4'd1;
            end
        end else begin
            drain_n = drain_q + 2'd1;
        end

        shamt = pm_n - p_n;
        twice = {i_n, 1'b0};
        tw0   = twice >> shamt;
        tw1   = (twice | 10'd1) >> shamt;

        k_n  = 9'd0;
        g0_n = 11'd0;
        g1_n = 11'd0;
        op_n = (state_n == S_INTT) || (state_n == S_SCALE);
        sa_n = (state_n == S_SCALE);
        if ((state_n == S_NTT) || (state_n == S_INTT)) begin
            k_n  = tw0[8:0];
            g0_n = (11'd1 << p_n) + {1'b0, tw0};
            g1_n = (11'd1 << p_n) + {1'b0, tw1};
            if (state_n == S_INTT) begin
                g0_n = g0_n + 11'd1024;
                g1_n = g1_n + 11'd1024;
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= S_IDLE;
            pm_q        <= 4'd0;
            drain_q     <= 2'd0;
            start_q     <= 1'b1;
            ren         <= 1'b0;
            i           <= 9'd0;
            p           <= 4'd0;
            k           <= 9'd0;
            gamma0      <= 11'd0;
            gamma1      <= 11'd0;
            op          <= 1'b0;
            special_add <= 1'b0;
        end else begin
            state_q     <= state_n;
            pm_q        <= pm_n;
            drain_q     <= drain_n;
            start_q     <= start;
            ren         <= ren_n;
            i           <= i_n;
            p           <= p_n;
            k           <= k_n;
            gamma0      <= g0_n;
            gamma1      <= g1_n;
            op          <= op_n;
            special_add <= sa_n;
        end
    end

    // Write enable trails read enable by the three-cycle butterfly latency
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            ren_pipe <= 2'b00;
            wen      <= 1'b0;
        end else begin
            ren_pipe <= {ren_pipe[0], ren};
            wen      <= ren_pipe[1];
        end
    end

endmodule

// File: tb/tb_ctrl.sv
// tb/tb_ctrl.sv - self-checking bench for ctrl against a pass-trace model
module tb_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  set_state = 3'd0;
    logic [3:0]  p_max = 4'd0;
    logic        op, ren, wen, special_add;
    logic [3:0]  p;
    logic [8:0]  k, i;
    logic [10:0] gamma0, gamma1;
    logic [2:0]  cur_state;

    ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .set_state(set_state), .p_max(p_max),
        .op(op), .p(p), .k(k), .i(i), .gamma0(gamma0), .gamma1(gamma1),
        .cur_state(cur_state), .ren(ren), .wen(wen), .special_add(special_add)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; bit rd; int ii; int pp; int kk; int g0; int g1; bit o; bit sa; bit tw;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   r1, r2, r3, prev_start;
    bit   was_idle;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e = '{default: 0};
        e.tw = 1'b1;
        return e;
    endfunction

    // Expected per-cycle trace of a whole operation, straight from the stage/twiddle rules
    task automatic build(input int st, input int pm);
        int m, np;
        m  = 1 << (pm - 1);
        np = (st == 1 || st == 3) ? pm + 1 : 1;
        for (int s = 0; s < np; s++) begin
            int pp;
            pp = (st == 1) ? s : (st == 3) ? pm - s : 0;
            for (int ii = 0; ii < m; ii++) begin
                exp_t e;
                e = idle_e();
                e.st = st; e.rd = 1'b1; e.ii = ii; e.pp = pp;
                e.o = (st == 3 || st == 4); e.sa = (st == 4);
                if (st == 1 || st == 3) begin
                    e.kk = (2 * ii) >> (pm - pp);
                    e.g0 = (1 << pp) + ((2 * ii) >> (pm - pp)) + (st == 3 ? 1024 : 0);
                    e.g1 = (1 << pp) + ((2 * ii + 1) >> (pm - pp)) + (st == 3 ? 1024 : 0);
                end
                q.push_back(e);
            end
            for (int d = 0; d < 3; d++) begin
                exp_t e;
                e = idle_e();
                e.st = st; e.pp = pp; e.tw = 1'b0;
                e.o = (st == 3 || st == 4); e.sa = (st == 4);
                q.push_back(e);
            end
        end
    endtask

    // Model: advances one trace entry per clock, launches on a fresh start edge while idle
    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            q.delete();
            cur = idle_e();
            r1 = 0; r2 = 0; r3 = 0;
            prev_start = 1;
        end else begin
            was_idle = (cur.st == 0);
            r3 = r2; r2 = r1; r1 = cur.rd;
            if (q.size() > 0) cur = q.pop_front();
            else cur = idle_e();
            if (was_idle && start && !prev_start && set_state >= 3'd1 && set_state <= 3'd4) begin
                build(int'(set_state), int'(p_max));
                cur = q.pop_front();
            end
            prev_start = int'(start);
        end
    end

    // Compare DUT against model every cycle
    always @(negedge clk) begin
        chk("cur_state", cur_state, cur.st);
        chk("ren", ren, cur.rd);
        chk("wen", wen, r3);
        chk("i", i, cur.ii);
        chk("p", p, cur.pp);
        chk("op", op, cur.o);
        chk("special_add", special_add, cur.sa);
        if (cur.tw) begin
            chk("k", k, cur.kk);
            chk("gamma0", gamma0, cur.g0);
            chk("gamma1", gamma1, cur.g1);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic launch(input int st, input int pm);
        set_state = 3'(st);
        p_max = 4'(pm);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (cur_state != 3'd0 && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", cur_state, 0);
    endtask

    initial begin
        int busy, hit1, hit2, renc, wenc, first_wen, cyc, maxg1;
        int ps[$];

        #1 rstn = 1'b1;
        step(3);
        chk("rst_state", cur_state, 0);
        chk("rst_ren", ren, 0);
        chk("rst_gamma1", gamma1, 0);
        rstn = 1'b0;
        step(2);

        // NTT p_max=4 with start held 3 cycles, a stray start pulse and input changes mid-run
        set_state = 3'd1; p_max = 4'd4; start = 1'b1;
        busy = 0; hit1 = 0; hit2 = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (c == 2) start = 1'b0;
            if (c == 10) begin set_state = 3'd3; p_max = 4'd2; end
            if (c == 20) start = 1'b1;
            if (c == 21) start = 1'b0;
            if (cur_state != 3'd0) busy++;
            if (ren && p == 4'd2 && i == 9'd5) begin
                chk("ntt_p2_k", k, 2);
                chk("ntt_p2_g0", gamma0, 6);
                chk("ntt_p2_g1", gamma1, 6);
                hit1 = 1;
            end
            if (ren && p == 4'd4 && i == 9'd3) begin
                chk("ntt_p4_g0", gamma0, 22);
                chk("ntt_p4_g1", gamma1, 23);
                hit2 = 1;
            end
            if (busy > 0 && cur_state == 3'd0) break;
        end
        chk("ntt_busy_cycles", busy, 55);
        chk("ntt_hit_p2", hit1, 1);
        chk("ntt_hit_p4", hit2, 1);
        step(2);

        // PWM p_max=2; start edge coincides with the return to IDLE
        launch(2, 2);
        chk("pwm_k", k, 0);
        step(4);
        start = 1'b1;
        step();
        chk("pwm_return_idle", cur_state, 0);
        step(3);
        chk("pwm_edge_ignored", cur_state, 0);
        start = 1'b0;
        step();

        // INTT p_max=4
        launch(3, 4);
        chk("intt_g0", gamma0, 1040);
        chk("intt_g1", gamma1, 1041);
        chk("intt_op", op, 1);
        ps.delete();
        ps.push_back(int'(p));
        cyc = 0;
        while (cur_state != 3'd0 && cyc < 200) begin
            step();
            cyc++;
            if (ren && i == 9'd0) ps.push_back(int'(p));
        end
        chk("intt_idle", cur_state, 0);
        chk("intt_passes", ps.size(), 5);
        if (ps.size() == 5)
            for (int j = 0; j < 5; j++) chk("intt_p_seq", ps[j], 4 - j);
        step();

        // SCALE p_max=4
        launch(4, 4);
        chk("scale_sa", special_add, 1);
        chk("scale_op", op, 1);
        renc = 0; wenc = 0; first_wen = -1; cyc = 0;
        while (cyc < 100) begin
            if (ren) renc++;
            if (wen) begin
                wenc++;
                if (first_wen < 0) first_wen = cyc;
            end
            if (cur_state == 3'd0) break;
            step();
            cyc++;
        end
        chk("scale_ren_cycles", renc, 8);
        chk("scale_wen_cycles", wenc, 8);
        chk("scale_wen_offset", first_wen, 3);
        step();

        // No-op set_state values
        for (int s = 0; s < 8; s++) begin
            if (s >= 1 && s <= 4) continue;
            set_state = 3'(s);
            start = 1'b1;
            step();
            chk("noop_state", cur_state, 0);
            start = 1'b0;
            step();
        end

        // Asynchronous reset in the middle of an NTT
        launch(1, 4);
        step(20);
        chk("pre_reset_busy", cur_state, 1);
        @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        chk("async_rst_state", cur_state, 0);
        chk("async_rst_ren", ren, 0);
        chk("async_rst_i", i, 0);
        chk("async_rst_p", p, 0);
        chk("async_rst_g0", gamma0, 0);
        start = 1'b1;
        step(2);
        rstn = 1'b0;
        step(5);
        chk("post_rst_no_launch", cur_state, 0);
        start = 1'b0;
        step();

        // Minimum length: p_max=1, PWM then NTT
        launch(2, 1);
        wait_idle(50);
        step();
        launch(1, 1);
        wait_idle(50);
        step();

        // Maximum length: p_max=9 NTT
        launch(1, 9);
        maxg1 = 0; cyc = 0;
        while (cur_state != 3'd0 && cyc < 3000) begin
            if (ren && p == 4'd9 && int'(gamma1) > maxg1) maxg1 = int'(gamma1);
            step();
            cyc++;
        end
        chk("pm9_idle", cur_state, 0);
        chk("pm9_max_gamma1", maxg1, 1023);
        chk("pm9_cycles", cyc, 2590);
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
